// File: rtl/sd_spi_master_if.sv
// SD card SPI master bundle: the Z80-side byte handshake plus the three SPI wires.
// The host drives start/din/slow and the card drives sddi; the master drives the rest.
interface sd_spi_master_if;
    logic       start;
    logic [7:0] din;
    logic       slow;
    logic [7:0] dout;
    logic       busy;
    logic       done;
    logic       sdclk;
    logic       sddo;
    logic       sddi;

    modport master (
        output start, din, slow, sddi,
        input  dout, busy, done, sdclk, sddo
    );

    modport slave (
        input  start, din, slow, sddi,
        output dout, busy, done, sdclk, sddo
    );
endinterface

// File: rtl/sd_spi_master.sv
// Byte-wide SPI master for the SD card, mode 0, MSB first.
// One start pulse shifts din out on sddo while collecting eight sddi bits, which
// are then held on dout until the next completion or reset.
module sd_spi_master #(
    parameter int unsigned FASTDIV = 2,
    parameter int unsigned SLOWDIV = 64
) (
    input logic              fclk,
    input logic              rst,
    sd_spi_master_if.slave   bus
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] div_q, div_d;
    logic [7:0] hcnt_q, hcnt_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic       sample_q, sample_d;
    logic       sdclk_q, sdclk_d;
    logic       sddo_q, sddo_d;
    logic [7:0] dout_q, dout_d;
    logic       done_q, done_d;

    logic       hcnt_wrap;
    logic       last_bit;

    // End of an SCK half-period, and the terminal flag for the eighth bit.
    assign hcnt_wrap = (hcnt_q == (div_q - 8'd1));
    assign last_bit  = (bcnt_q == 3'd7);

    // Next-state logic: accept in idle, then toggle SCK every div_q cycles.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        div_d    = div_q;
        hcnt_d   = hcnt_q;
        bcnt_d   = bcnt_q;
        sample_d = sample_q;
        sdclk_d  = sdclk_q;
        sddo_d   = sddo_q;
        dout_d   = dout_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    shreg_d = bus.din;
                    div_d   = bus.slow ? 8'(SLOWDIV) : 8'(FASTDIV);
                    hcnt_d  = 8'd0;
                    bcnt_d  = 3'd0;
                    // MSB goes out now so it has a full half-period of setup.
                    sddo_d  = bus.din[7];
                    state_d = StShift;
                end
            end
            StShift: begin
                if (hcnt_wrap) begin
                    hcnt_d  = 8'd0;
                    sdclk_d = ~sdclk_q;
                    if (!sdclk_q) begin
                        // Rising SCK: capture the card's bit.
                        sample_d = bus.sddi;
                    end else begin
                        // Falling SCK: shift, and present the next MSB.
                        shreg_d = {shreg_q[6:0], sample_q};
                        bcnt_d  = bcnt_q + 3'd1;
                        if (last_bit) begin
                            // sddo keeps the last transmitted bit while idle.
                            dout_d  = {shreg_q[6:0], sample_q};
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end else begin
                            sddo_d = shreg_q[6];
                        end
                    end
                end else begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset; reset also aborts a transfer.
    always_ff @(posedge fclk) begin
        if (rst) begin
            state_q  <= StIdle;
            shreg_q  <= 8'hFF;
            div_q    <= 8'(FASTDIV);
            hcnt_q   <= 8'd0;
            bcnt_q   <= 3'd0;
            sample_q <= 1'b1;
            sdclk_q  <= 1'b0;
            sddo_q   <= 1'b1;
            dout_q   <= 8'hFF;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            div_q    <= div_d;
            hcnt_q   <= hcnt_d;
            bcnt_q   <= bcnt_d;
            sample_q <= sample_d;
            sdclk_q  <= sdclk_d;
            sddo_q   <= sddo_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
        end
    end

    assign bus.dout  = dout_q;
    assign bus.busy  = (state_q == StShift);
    assign bus.done  = done_q;
    assign bus.sdclk = sdclk_q;
    assign bus.sddo  = sddo_q;

endmodule

// File: doc/sd_spi_master.md
Name: sd_spi_master

Overview:
- Byte-wide SPI master that drives the SD card.
- Sits on the fclk side of the Z80 SD port logic. It consumes the already-resynchronised one-fclk start pulse and the write byte, shifts 8 bits out on SDDO while sampling 8 bits from SDDI, then presents the received byte for Z80 reads of the SD data port.
- Runs in SPI mode 0, MSB first.
- Has a slow clock mode for card initialisation (≤400 kHz).

Parameters:
- FASTDIV, 2, fclk cycles per SCK half-period in normal mode; legal range 1..255.
- SLOWDIV, 64, fclk cycles per SCK half-period when slow=1; legal range 1..255.

Ports:
- fclk  in  1  global FPGA clock; the only clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-fclk pulse requesting a byte transfer.
- din  in  8  byte to transmit; sampled on the fclk edge that accepts start. Z80 reads supply FF here.
- slow  in  1  selects SLOWDIV; sampled on the fclk edge that accepts start.
- dout  out  8  last received byte; stable between transfers.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-fclk pulse at transfer completion.
- sdclk  out  1  SPI SCK to the card.
- sddo  out  1  SPI MOSI to the card.
- sddi  in  1  SPI MISO from the card.

Behaviour:
- Reset: applied on any fclk edge with rst=1, including mid-transfer, which aborts the transfer with no done pulse. Values after reset:
  - sdclk=0, sddo=1, busy=0, done=0, dout=FF.
  - Internal shift register=FF; half-period counter=0; bit counter=0.
- Clocking: single clock domain (fclk); no internal synchronisers. sddi is sampled directly; the card is slow relative to fclk.
- States: IDLE and SHIFT.
- IDLE:
  - sdclk=0, busy=0.
  - sddo holds 1 after reset; after a transfer it keeps the last driven bit (bit 0 of the transmitted byte).
- Accept (edge E0, start=1 and busy=0):
  - Latch din into the shift register.
  - Latch the divider: SLOWDIV if slow=1, else FASTDIV.
  - Clear both counters; enter SHIFT; busy=1 from the next cycle.
  - Drive sddo=din[7] from the next cycle, giving a full half-period of setup before the first rising edge.
- Ignored starts:
  - start while busy=1 has no effect; a pulse lost this way is not queued.
  - start on the same edge as completion is ignored, because busy is still 1 on that edge.
- SHIFT timing:
  - The half-period counter counts DIV fclk cycles, then toggles sdclk and restarts.
  - Rising SCK edge: capture sddi into a sample flop.
  - Falling SCK edge: shift the register left by one, inserting the sampled bit at LSB; sddo takes the new MSB; increment the bit counter.
  - 8 rising and 8 falling SCK edges occur per byte, so busy stays high for exactly 16*DIV fclk cycles (E1..E16*DIV).
- Completion (the 8th falling edge, at E16*DIV):
  - sdclk returns to 0; busy=0.
  - dout loads the 8 received bits (first received bit is dout[7]).
  - done=1 for exactly the following cycle.
- Back-to-back transfers:
  - A start arriving in the cycle after completion is accepted.
  - Minimum byte period is 16*DIV+1 fclk cycles.
- Signal stability:
  - dout changes only at completion or reset.
  - slow changing mid-transfer has no effect.
  - SCK duty cycle is exactly 50 %.
- Counter widths: the half-period counter is 8 bits; the bit counter is 3 bits plus a terminal flag; there is no wrap beyond 8 bits per transfer.

Test Plan:
- Loopback: FASTDIV=2, sddo tied to sddi, start with din=A5, slow=0 -> busy high for exactly 32 cycles; 8 sdclk rising edges, each 2 cycles high and 2 low; dout=A5; one done pulse.
- Pattern check: sddi driven from a card model returning 3C, din=FF -> sddo stays 1 throughout; dout=3C; sdclk is 0 before and after the transfer.
- Slow mode: SLOWDIV=4, slow=1, din=00, card returns 81 -> busy for 64 cycles; sdclk half-period 4 cycles; dout=81. Toggling slow to 0 mid-transfer leaves timing unchanged.
- Start collision: second start pulses at E5 and on the completion edge -> both ignored; only one done pulse. A start at completion+1 launches a new 32-cycle transfer.
- Reset mid-transfer: rst pulsed at the 3rd SCK rising edge -> the next cycle shows sdclk=0, sddo=1, busy=0, dout=FF, and no done pulse. A later start with din=5A in loopback gives dout=5A.
- Reset idle defaults: after rst with no start -> dout=FF, busy=0, done=0, sdclk=0, sddo=1, all held indefinitely.
